// File: rtl/uart_pkg.sv
// UART shared definitions: receiver FSM states, CRC-8 polynomial and the
// byte-wise CRC-8 update used by both the receiver and the transmitter checksum.
package uart_pkg;

    localparam logic [7:0] CRC8_POLY = 8'h07;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_IDLE = 3'd5
    } rx_state_t;

    // MSB-first CRC-8, no reflection, no final XOR.
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc_in,
                                             input logic [7:0] data,
                                             input logic [7:0] poly);
        logic [7:0] c;
        c = crc_in ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ poly) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line. Resets to 1 so an
// idle line never looks like a start bit while coming out of reset.
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops; q is safe to use in the clk domain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_crc_receiver.sv
// UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) with a
// valid/ready holding register and a running CRC-8 over delivered bytes.
//
//  state     | meaning
//  ----------+----------------------------------------------------------
//  IDLE      | line idle, waiting for a synchronized 1->0 edge
//  START     | half-bit wait, confirm start bit is still low
//  DATA      | sample 8 data bits, LSB first, one per bit period
//  PARITY    | sample even-parity bit (UART_RX_PARITY_EN builds only)
//  STOP      | sample stop bit; good byte loads holding register
//  WAIT_IDLE | framing error seen, wait for the line to return high
module uart_rx_crc_receiver
    import uart_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 16,
    parameter logic [7:0] CRC_POLY     = CRC8_POLY
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    input  logic       crc_clear,
    output logic [7:0] crc_out
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

    rx_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;
    logic             rx_s;
    logic             rx_s_d;
    logic             tick;
    logic             byte_good;
    logic             load;
    logic             drop;
`ifdef UART_RX_PARITY_EN
    logic             parity_bad;
`endif

    uart_rx_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx_in),
        .q     (rx_s)
    );

    // Terminal count of the bit timer and the holding-register load decision.
    always_comb begin
        tick      = (cnt == '0);
        byte_good = (state == STOP) && tick && rx_s;
`ifdef UART_RX_PARITY_EN
        byte_good = byte_good && !parity_bad;
`endif
        drop      = byte_good && rx_valid && !rx_ready;
        load      = byte_good && !drop;
    end

    // Receive FSM with bit timer, bit index, shift register and error pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            rx_s_d     <= 1'b1;
            frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
            parity_bad <= 1'b0;
`endif
        end else begin
            rx_s_d    <= rx_s;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            if (!tick) begin
                cnt <= cnt - 1'b1;
            end
            case (state)
                IDLE: begin
                    if (rx_s_d && !rx_s) begin
                        state <= START;
                        cnt   <= CNT_HALF;
                    end
                end
                START: begin
                    if (tick) begin
                        if (!rx_s) begin
                            state   <= DATA;
                            cnt     <= CNT_FULL;
                            bit_idx <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        shift_reg <= {rx_s, shift_reg[7:1]};
                        cnt       <= CNT_FULL;
                        bit_idx   <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        parity_bad <= ^{shift_reg, rx_s};
                        parity_err <= ^{shift_reg, rx_s};
                        cnt        <= CNT_FULL;
                        state      <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
                        if (rx_s) begin
                            state <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= WAIT_IDLE;
                        end
                    end
                end
                WAIT_IDLE: begin
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Holding register, handshake, overrun pulse and running CRC.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
            crc_out  <= '0;
        end else begin
            overrun <= drop;
            if (load) begin
                rx_data  <= shift_reg;
                rx_valid <= 1'b1;
                crc_out  <= crc8_byte(crc_clear ? 8'h00 : crc_out, shift_reg, CRC_POLY);
            end else begin
                if (rx_valid && rx_ready) begin
                    rx_valid <= 1'b0;
                end
                if (crc_clear) begin
                    crc_out <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_crc_receiver.sv
// Bench for uart_rx_crc_receiver; parity cases run when UART_RX_PARITY_EN is defined.
module tb_uart_rx_crc_receiver;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx_in = 1'b1;
    logic       rx_ready = 1'b1;
    logic       crc_clear = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic [7:0] crc_out;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    uart_rx_crc_receiver #(.CLKS_PER_BIT(CPB), .CRC_POLY(8'h07)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_in     (rx_in),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .crc_clear (crc_clear),
        .crc_out   (crc_out)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    int         pe_cnt = 0;
    int         rise_cnt = 0;
    int         last_rise_cyc = 0;
    logic       prev_valid = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] model_crc = 8'h00;

    function automatic logic [7:0] crc8_model(input logic [7:0] c_in, input logic [7:0] d);
        logic [7:0] c;
        c = c_in ^ d;
        for (int i = 0; i < 8; i++) begin
            if (c[7]) c = {c[6:0], 1'b0} ^ 8'h07;
            else      c = {c[6:0], 1'b0};
        end
        return c;
    endfunction

    always @(posedge clk) cyc++;

    // Monitor: pulse counters and scoreboard pop on each handshake.
    always @(negedge clk) begin
        logic [7:0] e;
        if (frame_err) fe_cnt++;
        if (overrun) ov_cnt++;
`ifdef UART_RX_PARITY_EN
        if (parity_err) pe_cnt++;
`endif
        if (rx_valid && !prev_valid) begin
            rise_cnt++;
            last_rise_cyc = cyc;
        end
        prev_valid = rx_valid;
        if (reset && rx_valid && rx_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got byte %02h, required none pending", rx_data);
            end else begin
                e = exp_q.pop_front();
                if (rx_data !== e) begin
                    n_fail++;
                    $display("FAIL sb_byte: got %02h, required %02h", rx_data, e);
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        rx_in = b;
        tick(CPB);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(^d);
`endif
        send_bit(stop_b);
        rx_in = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick(3);
        @(negedge clk);
        n_checks++;
        if (rx_valid !== 1'b0 || rx_data !== 8'h00 || crc_out !== 8'h00 ||
            frame_err !== 1'b0 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got valid=%b data=%02h crc=%02h fe=%b ov=%b, required all 0",
                     rx_valid, rx_data, crc_out, frame_err, overrun);
        end
        tick(1);
        reset = 1'b1;
        tick(5);
    endtask

    task automatic test_basic();
        int r0, start_cyc, lat;
        r0 = rise_cnt;
        exp_q.push_back(8'hA5);
        model_crc = crc8_model(model_crc, 8'hA5);
        start_cyc = cyc;
        send_frame(8'hA5, 1'b1);
        tick(4);
        @(negedge clk);
        lat = last_rise_cyc - start_cyc;
        n_checks++;
        if (rise_cnt - r0 !== 1) begin
            n_fail++;
            $display("FAIL basic_valid_count: got %0d, required 1", rise_cnt - r0);
        end
        n_checks++;
        if (lat < CPB * 9 + 1 || lat > CPB * 10) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d cycles, required %0d..%0d", lat, CPB * 9 + 1, CPB * 10);
        end
        n_checks++;
        if (crc_out !== 8'h72) begin
            n_fail++;
            $display("FAIL basic_crc: got %02h, required 72", crc_out);
        end
        n_checks++;
        if (rx_data !== 8'hA5 || rx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_hold: got data=%02h valid=%b, required A5 / 0", rx_data, rx_valid);
        end
    endtask

    task automatic test_crc_stream();
        int r0;
        logic [7:0] b;
        crc_clear = 1'b1;
        tick(1);
        crc_clear = 1'b0;
        model_crc = 8'h00;
        @(negedge clk);
        n_checks++;
        if (crc_out !== 8'h00) begin
            n_fail++;
            $display("FAIL crc_clear: got %02h, required 00", crc_out);
        end
        r0 = rise_cnt;
        for (int i = 0; i < 9; i++) begin
            b = 8'h31 + 8'(i);
            exp_q.push_back(b);
            model_crc = crc8_model(model_crc, b);
            send_frame(b, 1'b1);
        end
        tick(20);
        n_checks++;
        if (crc_out !== 8'hF4 || crc_out !== model_crc) begin
            n_fail++;
            $display("FAIL crc_stream: got %02h, required F4 (model %02h)", crc_out, model_crc);
        end
        n_checks++;
        if (rise_cnt - r0 !== 9 || exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL stream_count: got %0d bytes, %0d pending, required 9 / 0",
                     rise_cnt - r0, exp_q.size());
        end
    endtask

    task automatic test_glitch();
        int r0, f0;
        r0 = rise_cnt;
        f0 = fe_cnt;
        rx_in = 1'b0;
        tick(5);
        rx_in = 1'b1;
        tick(3 * CPB);
        n_checks++;
        if (rise_cnt !== r0 || fe_cnt !== f0) begin
            n_fail++;
            $display("FAIL glitch: got valids=%0d frame_errs=%0d, required 0 / 0",
                     rise_cnt - r0, fe_cnt - f0);
        end
    endtask

    task automatic test_frame_err();
        int r0, f0;
        r0 = rise_cnt;
        f0 = fe_cnt;
        send_frame(8'h3C, 1'b0);
        rx_in = 1'b1;
        tick(20);
        n_checks++;
        if (fe_cnt - f0 !== 1 || rise_cnt !== r0) begin
            n_fail++;
            $display("FAIL frame_err: got pulses=%0d valids=%0d, required 1 / 0",
                     fe_cnt - f0, rise_cnt - r0);
        end
        n_checks++;
        if (crc_out !== model_crc) begin
            n_fail++;
            $display("FAIL frame_err_crc: got %02h, required %02h", crc_out, model_crc);
        end
        exp_q.push_back(8'h01);
        model_crc = crc8_model(model_crc, 8'h01);
        send_frame(8'h01, 1'b1);
        tick(10);
        n_checks++;
        if (rx_data !== 8'h01 || rise_cnt - r0 !== 1 || crc_out !== model_crc) begin
            n_fail++;
            $display("FAIL after_frame_err: got data=%02h valids=%0d crc=%02h, required 01 / 1 / %02h",
                     rx_data, rise_cnt - r0, crc_out, model_crc);
        end
    endtask

    task automatic test_overrun();
        int o0;
        o0 = ov_cnt;
        rx_ready = 1'b0;
        exp_q.push_back(8'h11);
        model_crc = crc8_model(model_crc, 8'h11);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        tick(10);
        @(negedge clk);
        n_checks++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin
            n_fail++;
            $display("FAIL overrun_hold: got valid=%b data=%02h, required 1 / 11", rx_valid, rx_data);
        end
        n_checks++;
        if (ov_cnt - o0 !== 1) begin
            n_fail++;
            $display("FAIL overrun_pulse: got %0d pulses, required 1", ov_cnt - o0);
        end
        n_checks++;
        if (crc_out !== model_crc) begin
            n_fail++;
            $display("FAIL overrun_crc: got %02h, required %02h", crc_out, model_crc);
        end
        tick(1);
        rx_ready = 1'b1;
        tick(3);
        @(negedge clk);
        n_checks++;
        if (rx_valid !== 1'b0 || exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL overrun_drain: got valid=%b pending=%0d, required 0 / 0",
                     rx_valid, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        rx_ready = 1'b0;
        send_frame(8'h5A, 1'b1);
        tick(5);
        @(negedge clk);
        n_checks++;
        if (rx_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_valid: got %b, required 1", rx_valid);
        end
        tick(1);
        send_bit(1'b0);
        repeat (3) send_bit(1'b1);
        tick(5);
        reset = 1'b0;
        #1;
        n_checks++;
        if (rx_valid !== 1'b0 || rx_data !== 8'h00 || crc_out !== 8'h00 ||
            frame_err !== 1'b0 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: got valid=%b data=%02h crc=%02h fe=%b ov=%b, required all 0",
                     rx_valid, rx_data, crc_out, frame_err, overrun);
        end
        rx_in = 1'b1;
        rx_ready = 1'b1;
        tick(3);
        reset = 1'b1;
        model_crc = 8'h00;
        tick(5);
        exp_q.push_back(8'h55);
        model_crc = crc8_model(model_crc, 8'h55);
        send_frame(8'h55, 1'b1);
        tick(10);
        @(negedge clk);
        n_checks++;
        if (rx_data !== 8'h55 || crc_out !== model_crc) begin
            n_fail++;
            $display("FAIL after_reset: got data=%02h crc=%02h, required 55 / %02h",
                     rx_data, crc_out, model_crc);
        end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int r0, p0;
        logic [7:0] d;
        d = 8'h07;
        r0 = rise_cnt;
        p0 = pe_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(1'b0);
        send_bit(1'b1);
        tick(10);
        n_checks++;
        if (pe_cnt - p0 !== 1 || rise_cnt !== r0) begin
            n_fail++;
            $display("FAIL parity_err: got pulses=%0d valids=%0d, required 1 / 0",
                     pe_cnt - p0, rise_cnt - r0);
        end
        n_checks++;
        if (crc_out !== model_crc) begin
            n_fail++;
            $display("FAIL parity_crc: got %02h, required %02h", crc_out, model_crc);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_crc_stream();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_reset_mid();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        tick(5);
        n_checks++;
        if (exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL sb_leftover: got %0d pending bytes, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
